// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decode-stage front end. Classifies the RV32 opcode into an
// immediate-format code, builds the immediate with the extend unit, and buffers
// results in a 2-entry skid FIFO so execute sees fully registered outputs.
// Optional feature macro: IMM_DECODE_ILLEGAL_TRAP_EN (sticky trap_hold on an
// illegal opcode, blocking intake until flush or reset).

// extend: RV32 immediate generator. Unknown format codes produce zero.
module extend (
  input  logic [31:7] instr,
  input  logic [2:0]  immsrc,
  output logic [31:0] immext
);
  // Combinational format mux
  always_comb begin
    immext = 32'h0;
    case (immsrc)
      3'b000: immext = {{20{instr[31]}}, instr[31:20]};
      3'b001: immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: immext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: immext = {instr[31:12], 12'h000};
      3'b100: immext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immext = 32'h0;
    endcase
  end
endmodule

module imm_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  extend_ctrl_out,
  output logic [31:0] imm_out,
  output logic        illegal_out
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  ctrl;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]  count;
  entry_t      head, tail, new_entry;
  logic [2:0]  dec_ctrl;
  logic        dec_illegal;
  logic [31:0] ext_imm;
  logic        trap_hold;
  logic        enq, deq;

  // Opcode to immediate-format classification
  always_comb begin
    dec_ctrl    = 3'b111;
    dec_illegal = 1'b0;
    case (instr_in[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec_ctrl = 3'b000;
      7'b0100011:             dec_ctrl = 3'b001;
      7'b1100011:             dec_ctrl = 3'b010;
      7'b0110111, 7'b0010111: dec_ctrl = 3'b011;
      7'b1101111:             dec_ctrl = 3'b100;
      7'b0110011:             dec_ctrl = 3'b111;
      default:                dec_illegal = 1'b1;
    endcase
  end

  extend u_extend (
    .instr  (instr_in[31:7]),
    .immsrc (dec_ctrl),
    .immext (ext_imm)
  );

  // Assemble the entry; formats without an immediate store zero regardless
  // of what the extender presents.
  always_comb begin
    new_entry.instr   = instr_in;
    new_entry.pc      = pc_in;
    new_entry.ctrl    = dec_ctrl;
    new_entry.imm     = (dec_ctrl == 3'b111) ? 32'h0 : ext_imm;
    new_entry.illegal = dec_illegal;
  end

  assign in_ready  = (count != CNT_FULL) && !rst && !trap_hold;
  assign out_valid = (count != CNT_EMPTY);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

`ifdef IMM_DECODE_ILLEGAL_TRAP_EN
  // Sticky hold after accepting an illegal beat; only flush or reset releases it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         trap_hold <= 1'b0;
    else if (flush)                  trap_hold <= 1'b0;
    else if (enq && dec_illegal)     trap_hold <= 1'b1;
  end
`else
  assign trap_hold = 1'b0;
`endif

  // Skid FIFO: count is the state, head feeds the outputs directly.
  // Flush wins over enq/deq; a dequeue in the flush cycle is still consumed
  // by execute, so nothing further is needed for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= CNT_EMPTY;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (count == CNT_EMPTY) head <= new_entry;
          else                    tail <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == CNT_FULL) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1 (no intake when full, no deq when empty)
          head <= new_entry;
        end
        default: ;
      endcase
    end
  end

  assign instr_out       = head.instr;
  assign pc_out          = head.pc;
  assign extend_ctrl_out = head.ctrl;
  assign imm_out         = head.imm;
  assign illegal_out     = head.illegal;

  logic unused_ok;
  assign unused_ok = ^{CNT_ONE};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: stimulus pushes hand-computed
// expected entries, a negedge monitor pops and compares on every dequeue.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal_out;
  logic [31:0] instr_in, pc_in, instr_out, pc_out, imm_out;
  logic [2:0]  extend_ctrl_out;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  ctrl;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t cur_exp;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  imm_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out),
    .extend_ctrl_out(extend_ctrl_out), .imm_out(imm_out),
    .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare head on dequeue, then model flush and enqueue
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_deq: got instr %h expected no entry", instr_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("instr", instr_out, e.instr);
          chk("pc", pc_out, e.pc);
          chk("ctrl", {29'h0, extend_ctrl_out}, {29'h0, e.ctrl});
          chk("imm", imm_out, e.imm);
          chk("illegal", {31'h0, illegal_out}, {31'h0, e.ill});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  // Offer one beat until accepted (bounded), return 1ns after the accepting edge
  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [2:0] c,
                      input logic [31:0] im, input logic il);
    bit ok = 0;
    instr_in = i; pc_in = p; in_valid = 1'b1;
    cur_exp = '{instr: i, pc: p, ctrl: c, imm: im, ill: il};
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: instr %h never accepted", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_in = 32'h0; pc_in = 32'h0;
    cur_exp = '{instr: 32'h0, pc: 32'h0, ctrl: 3'b0, imm: 32'h0, ill: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_imm", imm_out, 32'h0);
    chk("rst_ctrl", {29'h0, extend_ctrl_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // addi x1,x0,-1
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h0000_0100, 3'b000, 32'hFFFFFFFF, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_out_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;

    // Back-to-back stream: sw, beq (offset -4), lui, jal (offset -4)
    send(32'hFE112E23, 32'h0000_0104, 3'b001, 32'hFFFFFFFC, 1'b0);
    send(32'hFE000EE3, 32'h0000_0108, 3'b010, 32'hFFFFFFFC, 1'b0);
    send(32'h123450B7, 32'h0000_010C, 3'b011, 32'h12345000, 1'b0);
    send(32'hFFDFF06F, 32'h0000_0110, 3'b100, 32'hFFFFFFFC, 1'b0);
    idle(3);

    // Backpressure: two beats fill the skid, third waits
    out_ready = 1'b0;
    send(32'h00A00113, 32'h0000_0200, 3'b000, 32'h0000000A, 1'b0);
    send(32'h00B02023, 32'h0000_0204, 3'b001, 32'h00000000, 1'b0);
    instr_in = 32'h00C00193; pc_in = 32'h0000_0208; in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    chk("full_out_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00C00193, 32'h0000_0208, 3'b000, 32'h0000000C, 1'b0);
    idle(4);

    // Flush at count 2 with a beat offered
    out_ready = 1'b0;
    send(32'h0010_0093, 32'h0000_0300, 3'b000, 32'h00000001, 1'b0);
    send(32'h0020_0093, 32'h0000_0304, 3'b000, 32'h00000002, 1'b0);
    instr_in = 32'h0030_0093; pc_in = 32'h0000_0308; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);

    // Illegal opcode 0000000
    send(32'h0000_0000, 32'h0000_0400, 3'b111, 32'h00000000, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef IMM_DECODE_ILLEGAL_TRAP_EN
    chk("trap_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap_in_ready_held", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("trap_release", {31'h0, in_ready}, 32'h1);
`else
    chk("illegal_in_ready", {31'h0, in_ready}, 32'h1);
`endif
    @(posedge clk); #1;
    // R-type add: no immediate, not illegal
    send(32'h002081B3, 32'h0000_0404, 3'b111, 32'h00000000, 1'b0);
    idle(3);

    // Asynchronous reset with one entry held
    out_ready = 1'b0;
    send(32'h7FF00093, 32'h0000_0500, 3'b000, 32'h000007FF, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_imm", imm_out, 32'h0);
    chk("arst_ctrl", {29'h0, extend_ctrl_out}, 32'h0);
    chk("arst_illegal", {31'h0, illegal_out}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rel_out_valid", {31'h0, out_valid}, 32'h0);

    chk("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
